// File: rtl/neuromorphic_x1_ctrl_if.sv
// Host-side command/response handshake bundle for the X1 macro controller.
// master: host (drives cmd_*, rsp_ready); slave: controller (drives cmd_ready, rsp_*).
interface neuromorphic_x1_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/neuromorphic_x1_ctrl.sv
// Controller bridging a valid/ready host port to the X1 macro EN/func_ack bus.
// Ports: CLKin/RSTin, host (slave modport), macro EN/R_WB/AD/DI/SEL/func_ack/DO, busy, spurious_ack.
module neuromorphic_x1_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic                        CLKin,
    input  logic                        RSTin,
    neuromorphic_x1_ctrl_if.slave       host,
    output logic                        EN,
    output logic                        R_WB,
    output logic [31:0]                 AD,
    output logic [31:0]                 DI,
    output logic [3:0]                  SEL,
    input  logic                        func_ack,
    input  logic [31:0]                 DO,
    output logic                        busy,
    output logic                        spurious_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // Counter value seen on the last allowed EN cycle.
    localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] ad_q, ad_d;
    logic [31:0] di_q, di_d;
    logic [3:0]  sel_q, sel_d;
    logic        rwb_q, rwb_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        spur_q, spur_d;

    always_comb begin
        state_d = state_q;
        ad_d    = ad_q;
        di_d    = di_q;
        sel_d   = sel_q;
        rwb_d   = rwb_q;
        wcnt_d  = wcnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // An ack is only meaningful while a transaction is on the macro bus.
        spur_d  = spur_q | (func_ack & (state_q != S_ISSUE));

        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    ad_d    = host.cmd_addr;
                    di_d    = host.cmd_wdata;
                    sel_d   = host.cmd_sel;
                    rwb_d   = ~host.cmd_write;
                    wcnt_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Ack is checked first so it wins on the timeout cycle.
                if (func_ack) begin
                    rdata_d = rwb_q ? DO : 32'd0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wcnt_q == WAIT_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (host.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKin) begin
        if (RSTin) begin
            state_q <= S_IDLE;
            ad_q    <= '0;
            di_q    <= '0;
            sel_q   <= '0;
            rwb_q   <= 1'b1;
            wcnt_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ad_q    <= ad_d;
            di_q    <= di_d;
            sel_q   <= sel_d;
            rwb_q   <= rwb_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
        end
    end

    // Ready is masked while reset is held so no command slips in.
    assign host.cmd_ready = (state_q == S_IDLE) & ~RSTin;
    assign host.rsp_valid = (state_q == S_RESP);
    assign host.rsp_rdata = rdata_q;
    assign host.rsp_err   = err_q;

    assign EN           = (state_q == S_ISSUE);
    assign R_WB         = rwb_q;
    assign AD           = ad_q;
    assign DI           = di_q;
    assign SEL          = sel_q;
    assign busy         = (state_q != S_IDLE);
    assign spurious_ack = spur_q;

endmodule

// File: tb/tb_neuromorphic_x1_ctrl.sv
// Self-checking bench for neuromorphic_x1_ctrl against a transaction-level model.
// Drives and samples on the falling clock edge; DUT runs with a short ack timeout.
module tb_neuromorphic_x1_ctrl;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        en, r_wb, func_ack, busy, spur;
    logic [31:0] ad, di, do_v;
    logic [3:0]  sel;

    int n_vec;
    int n_err;
    bit spur_exp;

    neuromorphic_x1_ctrl_if hif ();

    neuromorphic_x1_ctrl #(.ACK_TIMEOUT(TMO)) dut (
        .CLKin        (clk),
        .RSTin        (rst),
        .host         (hif.slave),
        .EN           (en),
        .R_WB         (r_wb),
        .AD           (ad),
        .DI           (di),
        .SEL          (sel),
        .func_ack     (func_ack),
        .DO           (do_v),
        .busy         (busy),
        .spurious_ack (spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction; ack_at = EN cycle on which func_ack is pulsed, 0 = never.
    task automatic run_txn(input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s,
                           input int ack_at, input logic [31:0] dv,
                           input int bp);
        int          en_cnt;
        int          exp_en;
        bit          exp_err;
        logic [31:0] exp_rd;
        exp_err = !(ack_at > 0 && ack_at <= TMO);
        exp_en  = exp_err ? TMO : ack_at;
        exp_rd  = (!wr && !exp_err) ? dv : 32'd0;

        check("idle_ready", hif.cmd_ready, 1);
        hif.cmd_valid = 1'b1;
        hif.cmd_write = wr;
        hif.cmd_addr  = a;
        hif.cmd_wdata = wd;
        hif.cmd_sel   = s;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        hif.cmd_addr  = $urandom;
        hif.cmd_wdata = $urandom;
        en_cnt = 0;
        while (en === 1'b1 && en_cnt < 64) begin
            en_cnt++;
            check("ad", ad, a);
            check("di", di, wd);
            check("sel", {28'd0, sel}, {28'd0, s});
            check("r_wb", r_wb, !wr);
            check("issue_nrdy", hif.cmd_ready, 0);
            if (en_cnt == ack_at) begin
                func_ack = 1'b1;
                do_v     = dv;
            end
            @(negedge clk);
            func_ack = 1'b0;
            do_v     = $urandom;
        end
        check("en_len", en_cnt, exp_en);
        for (int i = 0; i <= bp; i++) begin
            check("rsp_valid", hif.rsp_valid, 1);
            check("rsp_rdata", hif.rsp_rdata, exp_rd);
            check("rsp_err", hif.rsp_err, exp_err);
            check("resp_nrdy", hif.cmd_ready, 0);
            check("resp_en", en, 0);
            check("resp_busy", busy, 1);
            if (i == bp) hif.rsp_ready = 1'b1;
            @(negedge clk);
        end
        hif.rsp_ready = 1'b0;
        check("done_valid", hif.rsp_valid, 0);
        check("done_en", en, 0);
        check("done_busy", busy, 0);
        check("spurious", spur, spur_exp);
    endtask

    initial begin
        logic [31:0] da, db;
        n_vec = 0;
        n_err = 0;
        spur_exp = 1'b0;
        rst = 1'b1;
        func_ack = 1'b0;
        do_v = 32'd0;
        hif.cmd_valid = 1'b0;
        hif.cmd_write = 1'b0;
        hif.cmd_addr  = 32'hFFFF_FFFF;
        hif.cmd_wdata = 32'hFFFF_FFFF;
        hif.cmd_sel   = 4'hF;
        hif.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_en", en, 0);
        check("rst_rwb", r_wb, 1);
        check("rst_ad", ad, 0);
        check("rst_di", di, 0);
        check("rst_sel", {28'd0, sel}, 0);
        check("rst_rvalid", hif.rsp_valid, 0);
        check("rst_rdata", hif.rsp_rdata, 0);
        check("rst_err", hif.rsp_err, 0);
        check("rst_spur", spur, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", hif.cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", hif.cmd_ready, 1);
        @(negedge clk);

        run_txn(1'b0, 32'h10, 32'h0, 4'h2, 3, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 32'h1F, 32'h1234_5678, 4'h5, 1, 32'hAAAA_5555, 5);
        run_txn(1'b0, 32'h40, 32'h0, 4'h1, 0, 32'h0, 1);
        run_txn(1'b0, 32'h44, 32'h0, 4'h3, TMO, 32'h5, 0);

        // Reset pulsed in the 2nd ISSUE cycle, ack arrives right after.
        hif.cmd_valid = 1'b1;
        hif.cmd_write = 1'b0;
        hif.cmd_addr  = 32'h80;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        check("abort_en1", en, 1);
        @(negedge clk);
        check("abort_en2", en, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_en_off", en, 0);
        check("abort_nvalid", hif.rsp_valid, 0);
        check("abort_rdy_rst", hif.cmd_ready, 0);
        rst = 1'b0;
        func_ack = 1'b1;
        @(negedge clk);
        func_ack = 1'b0;
        spur_exp = 1'b1;
        check("abort_spur", spur, 1);
        check("abort_ready", hif.cmd_ready, 1);
        check("abort_nvalid2", hif.rsp_valid, 0);

        // Back-to-back reads with cmd_valid held and immediate acks.
        da = $urandom;
        db = $urandom;
        hif.cmd_valid = 1'b1;
        hif.cmd_write = 1'b0;
        hif.cmd_addr  = 32'hA0;
        hif.rsp_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            func_ack = 1'b0;
            if (c == 1) hif.cmd_addr = 32'hB0;
            if (c == 4) hif.cmd_valid = 1'b0;
            check("b2b_en", en, (c == 1 || c == 4));
            check("b2b_rv", hif.rsp_valid, (c == 2 || c == 5));
            if (c == 1) check("b2b_ad_a", ad, 32'hA0);
            if (c == 4) check("b2b_ad_b", ad, 32'hB0);
            if (c == 2) check("b2b_rd_a", hif.rsp_rdata, da);
            if (c == 5) check("b2b_rd_b", hif.rsp_rdata, db);
            if (en === 1'b1) begin
                func_ack = 1'b1;
                do_v = (c == 1) ? da : db;
            end
        end
        func_ack = 1'b0;
        hif.rsp_ready = 1'b0;

        // Idle reset clears the sticky flag.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spur_exp = 1'b0;
        @(negedge clk);
        check("clr_spur", spur, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                func_ack = 1'b1;
                spur_exp = 1'b1;
                @(negedge clk);
                func_ack = 1'b0;
            end
            run_txn($urandom_range(0, 1) == 1, $urandom, $urandom,
                    4'($urandom), $urandom_range(0, TMO + 2), $urandom,
                    $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neuromorphic_x1_ctrl.md
NEUROMORPHIC_X1_CTRL -- requirements
Module: neuromorphic_x1_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: CLKin (rising edge) and RSTin, where RSTin is synchronous and active-high.
REQ-002 The block SHALL have this parameter: ACK_TIMEOUT, default 1023, meaning the number of cycles waited for func_ack before aborting (allowed range 1..65535).
REQ-003 CLKin  input  1  clock.
REQ-004 RSTin  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  controller accepts the command this cycle.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  32  macro address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_sel  input  4  macro function select.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  host accepts the response.
REQ-013 rsp_rdata  output  32  read data (0 for writes and for errors).
REQ-014 rsp_err  output  1  the transaction timed out.
REQ-015 EN  output  1  macro transaction enable.
REQ-016 R_WB  output  1  macro direction: 1 = read, 0 = write.
REQ-017 AD  output  32  macro address.
REQ-018 DI  output  32  macro write data.
REQ-019 SEL  output  4  macro select.
REQ-020 func_ack  input  1  macro completion pulse.
REQ-021 DO  input  32  macro read data, valid in the cycle func_ack is high.
REQ-022 busy  output  1  high in any state other than IDLE.
REQ-023 spurious_ack  output  1  sticky flag, set when func_ack is seen outside ISSUE.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-025 cmd_ready SHALL be 1 only in IDLE.
REQ-026 On cmd_valid and cmd_ready, the block SHALL register cmd_addr, cmd_wdata, cmd_sel and ~cmd_write into AD, DI, SEL and R_WB, then go to ISSUE next cycle.
REQ-027 In ISSUE, EN SHALL be 1, and AD, DI, SEL and R_WB SHALL be held stable.
REQ-028 Outside ISSUE, EN SHALL be 0.
REQ-029 AD, DI, SEL and R_WB SHALL retain their last value when not in ISSUE.
REQ-030 In ISSUE, a 16-bit wait counter SHALL load 0 on entry and increment every cycle that func_ack is 0.
REQ-031 func_ack=1 in ISSUE SHALL move the FSM to RESP, with the following capture: rsp_rdata = DO if read, else 0; rsp_err = 0.
REQ-032 If the wait counter reaches ACK_TIMEOUT-1 with func_ack=0, the FSM SHALL move to RESP with rsp_err = 1 and rsp_rdata = 0; EN therefore drops after exactly ACK_TIMEOUT cycles high.
REQ-033 If func_ack=1 on the timeout cycle, the ack SHALL win (rsp_err = 0).
REQ-034 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable until rsp_ready.
REQ-035 On rsp_ready in RESP, the FSM SHALL go to IDLE, guaranteeing at least one EN-low cycle between transactions.
REQ-036 func_ack=1 in IDLE or RESP SHALL set spurious_ack, SHALL otherwise be ignored, and SHALL NOT change state.
REQ-037 Minimum latency SHALL be: accept at cycle 0, EN at cycle 1, func_ack at cycle 1 giving rsp_valid at cycle 2.
REQ-038 Throughput SHALL be at most one transaction per 3 cycles.
REQ-039 cmd_* inputs SHALL be ignored outside IDLE.
REQ-040 rsp_ready outside RESP SHALL be ignored.

Reset
REQ-041 While RSTin=1 at a clock edge, the next state SHALL be IDLE, and the following outputs SHALL be forced: EN=0, R_WB=1, AD=0, DI=0, SEL=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, spurious_ack=0, busy=0, wait counter 0.
REQ-042 cmd_ready SHALL be 0 during reset and 1 on the first cycle after RSTin falls.
REQ-043 Reset asserted during ISSUE or RESP SHALL abort the transaction: EN=0 next cycle and no response is produced.
REQ-044 A func_ack arriving in the cycle after an abort SHALL set spurious_ack.

Verification
REQ-045 Read, ack after 3 cycles: read cmd, addr=0x0000_0010, sel=4'h2; func_ack on the 3rd EN cycle with DO=0xDEAD_BEEF -> EN high for 3 cycles with R_WB=1, AD=0x10, SEL=2; rsp_valid, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-046 Write with response backpressure: write cmd, addr=0x1F, wdata=0x1234_5678; immediate func_ack; rsp_ready held low 5 cycles -> DI=0x1234_5678, R_WB=0; rsp_valid held 5 cycles, rsp_rdata=0, cmd_ready=0 throughout.
REQ-047 Timeout: ACK_TIMEOUT=8, read cmd, func_ack never asserted -> EN high exactly 8 cycles, rsp_err=1, rsp_rdata=0.
REQ-048 Ack/timeout collision: ACK_TIMEOUT=8, func_ack on the 8th EN cycle with DO=0x5 -> rsp_err=0, rsp_rdata=0x5.
REQ-049 Reset mid-issue: RSTin pulsed in the 2nd ISSUE cycle -> EN=0 next cycle, no rsp_valid, cmd_ready=1 after reset; a func_ack in that window sets spurious_ack=1.
REQ-050 Back-to-back: two read cmds with cmd_valid held, rsp_ready=1, immediate acks -> EN low for at least 1 cycle between transactions, 3-cycle spacing, both responses in order.
